// File: rtl/clock_set_controller.sv
`default_nettype none
// ============================================================================
// Module      : clock_set_controller
// Description : Button-driven time/date setting controller. A mode button
//               steps RUN -> SET_SEC -> SET_MIN -> SET_HOUR -> SET_DAY ->
//               SET_MON -> SET_YEAR -> RUN. In a SET state, inc/dec button
//               edges become single-cycle pulses to the selected field
//               counter. An idle timeout returns to RUN, and a blink output
//               flashes the selected field.
//
// Optional    : CLOCK_SET_AUTO_REPEAT_EN - when defined, a held inc/dec button
//               auto-repeats after REPEAT_DELAY cycles, then every REPEAT_RATE
//               cycles. When undefined, each press yields exactly one pulse.
//
// Parameters  : TIMEOUT_CYC  - idle cycles in a SET state before return to RUN
//               REPEAT_DELAY - hold cycles before the first auto-repeat pulse
//               REPEAT_RATE  - cycles between successive auto-repeat pulses
//               BLINK_HALF   - cycles per half-period of blink
//
// Ports       : clk        in   sole clock, rising edge
//               rstn       in   asynchronous active-low reset
//               btn_mode   in   debounced mode button (level high)
//               btn_inc    in   debounced increment button (level high)
//               btn_dec    in   debounced decrement button (level high)
//               set_mode   out  high in every SET state
//               set_enable out  high in every SET state
//               field_sel  out  one-hot selected field
//                               (sec, min, hour, day, month, year)
//               inc        out  single-cycle increment pulse
//               dec        out  single-cycle decrement pulse
//               blink      out  display blink enable for the selected field
//
// Revision    : 1.0 - initial release
// ============================================================================
module clock_set_controller #(
    parameter int TIMEOUT_CYC  = 1000,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100,
    parameter int BLINK_HALF   = 250
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output logic       set_mode,
    output logic       set_enable,
    output logic [5:0] field_sel,
    output logic       inc,
    output logic       dec,
    output logic       blink
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_IDLE_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int c_BLINK_W = $clog2(BLINK_HALF + 1);

    localparam logic [c_IDLE_W-1:0]  c_IDLE_LAST  = c_IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_HALF - 1);

    // ------------------------------------------------------------------
    // Main mode FSM encoding
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_SET_SEC  = 3'd1,
        ST_SET_MIN  = 3'd2,
        ST_SET_HOUR = 3'd3,
        ST_SET_DAY  = 3'd4,
        ST_SET_MON  = 3'd5,
        ST_SET_YEAR = 3'd6
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Button history (previous-cycle levels) for rising-edge detection
    logic r_mode_q;
    logic r_inc_q;
    logic r_dec_q;

    logic w_mode_edge;
    logic w_inc_edge;
    logic w_dec_edge;
    logic w_any_edge;
    logic w_both;
    logic w_in_set;
    logic w_state_chg;
    logic w_timeout;
    logic w_pulse_ok;
    logic w_inc_first;
    logic w_dec_first;
    logic w_inc_fire;
    logic w_dec_fire;
    logic [5:0] w_field_nxt;

    logic [c_IDLE_W-1:0]  r_idle_cnt;
    logic [c_BLINK_W-1:0] r_blink_cnt;

    // ------------------------------------------------------------------
    // Edge detection and qualifiers
    // ------------------------------------------------------------------
    assign w_mode_edge = btn_mode & ~r_mode_q;
    assign w_inc_edge  = btn_inc  & ~r_inc_q;
    assign w_dec_edge  = btn_dec  & ~r_dec_q;
    assign w_any_edge  = w_mode_edge | w_inc_edge | w_dec_edge;
    assign w_both      = btn_inc & btn_dec;
    assign w_in_set    = (r_state != ST_RUN);
    assign w_state_chg = (w_state_nxt != r_state);

    // A button edge in the terminal idle cycle counts as activity, so the
    // timeout only fires on a genuinely quiet cycle.
    assign w_timeout = w_in_set && (r_idle_cnt >= c_IDLE_LAST) && !w_any_edge;

    // inc/dec edges are honoured only in SET states, never alongside a mode
    // edge, and never while both buttons are held (which also keeps inc and
    // dec mutually exclusive).
    assign w_pulse_ok  = w_in_set & ~w_mode_edge & ~w_both;
    assign w_inc_first = w_pulse_ok & w_inc_edge;
    assign w_dec_first = w_pulse_ok & w_dec_edge;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mode_q <= 1'b0;
            r_inc_q  <= 1'b0;
            r_dec_q  <= 1'b0;
        end else begin
            r_mode_q <= btn_mode;
            r_inc_q  <= btn_inc;
            r_dec_q  <= btn_dec;
        end
    end

    // ------------------------------------------------------------------
    // Main FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Main FSM: next state and field decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (w_mode_edge) begin
            case (r_state)
                ST_RUN:      w_state_nxt = ST_SET_SEC;
                ST_SET_SEC:  w_state_nxt = ST_SET_MIN;
                ST_SET_MIN:  w_state_nxt = ST_SET_HOUR;
                ST_SET_HOUR: w_state_nxt = ST_SET_DAY;
                ST_SET_DAY:  w_state_nxt = ST_SET_MON;
                ST_SET_MON:  w_state_nxt = ST_SET_YEAR;
                default:     w_state_nxt = ST_RUN;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = ST_RUN;
        end
    end

    always_comb begin
        w_field_nxt = 6'b000000;
        case (w_state_nxt)
            ST_SET_SEC:  w_field_nxt = 6'b000001;
            ST_SET_MIN:  w_field_nxt = 6'b000010;
            ST_SET_HOUR: w_field_nxt = 6'b000100;
            ST_SET_DAY:  w_field_nxt = 6'b001000;
            ST_SET_MON:  w_field_nxt = 6'b010000;
            ST_SET_YEAR: w_field_nxt = 6'b100000;
            default:     w_field_nxt = 6'b000000;
        endcase
    end

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    // ------------------------------------------------------------------
    // Auto-repeat FSM. The hold counter is reloaded to 1 on every pulse, so
    // a pulse at cycle N is followed by the next at N+REPEAT_DELAY (first
    // repeat) and then every REPEAT_RATE cycles. r_rep_fast marks which of
    // the two intervals is currently being timed.
    // ------------------------------------------------------------------
    localparam int c_HOLD_W = ($clog2(REPEAT_DELAY + 1) > $clog2(REPEAT_RATE + 1)) ?
                              $clog2(REPEAT_DELAY + 1) : $clog2(REPEAT_RATE + 1);
    localparam logic [c_HOLD_W-1:0] c_REP_DELAY = c_HOLD_W'(REPEAT_DELAY);
    localparam logic [c_HOLD_W-1:0] c_REP_RATE  = c_HOLD_W'(REPEAT_RATE);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX  = {c_HOLD_W{1'b1}};

    typedef enum logic {
        REP_IDLE = 1'b0,
        REP_HOLD = 1'b1
    } rep_state_t;

    rep_state_t          r_rep_state;
    rep_state_t          w_rep_nxt;
    logic                r_rep_dir;   // 1 = inc held, 0 = dec held
    logic                w_dir_nxt;
    logic                r_rep_fast;
    logic                w_fast_nxt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    logic                w_rep_held;
    logic                w_rep_cancel;
    logic                w_rep_fire;

    assign w_rep_held   = r_rep_dir ? btn_inc : btn_dec;
    assign w_rep_cancel = ~w_in_set | w_mode_edge | w_both | ~w_rep_held | w_state_chg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rep_state <= REP_IDLE;
            r_rep_dir   <= 1'b0;
            r_rep_fast  <= 1'b0;
            r_hold_cnt  <= '0;
        end else begin
            r_rep_state <= w_rep_nxt;
            r_rep_dir   <= w_dir_nxt;
            r_rep_fast  <= w_fast_nxt;
            r_hold_cnt  <= w_hold_nxt;
        end
    end

    always_comb begin
        w_rep_nxt  = r_rep_state;
        w_dir_nxt  = r_rep_dir;
        w_fast_nxt = r_rep_fast;
        w_hold_nxt = r_hold_cnt;
        w_rep_fire = 1'b0;
        if (w_inc_first || w_dec_first) begin
            w_rep_nxt  = REP_HOLD;
            w_dir_nxt  = w_inc_first;
            w_fast_nxt = 1'b0;
            w_hold_nxt = c_HOLD_W'(1);
        end else if (r_rep_state == REP_HOLD) begin
            if (w_rep_cancel) begin
                w_rep_nxt  = REP_IDLE;
                w_fast_nxt = 1'b0;
                w_hold_nxt = '0;
            end else if (r_rep_fast ? (r_hold_cnt >= c_REP_RATE)
                                    : (r_hold_cnt >= c_REP_DELAY)) begin
                w_rep_fire = 1'b1;
                w_fast_nxt = 1'b1;
                w_hold_nxt = c_HOLD_W'(1);
            end else if (r_hold_cnt != c_HOLD_MAX) begin
                w_hold_nxt = r_hold_cnt + 1'b1;
            end
        end
    end

    assign w_inc_fire = w_inc_first | (w_rep_fire &  r_rep_dir);
    assign w_dec_fire = w_dec_first | (w_rep_fire & ~r_rep_dir);
`else
    // Without auto-repeat each press yields exactly one pulse.
    assign w_inc_fire = w_inc_first;
    assign w_dec_fire = w_dec_first;
`endif

    // ------------------------------------------------------------------
    // Idle counter: runs in SET states, cleared by any activity
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idle_cnt <= '0;
        end else if (!w_in_set || w_state_chg || w_any_edge) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt < c_IDLE_LAST) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Blink generator: restarts high on every state change
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_blink_cnt <= '0;
            blink       <= 1'b0;
        end else if (w_state_chg) begin
            r_blink_cnt <= '0;
            blink       <= (w_state_nxt != ST_RUN);
        end else if (!w_in_set) begin
            r_blink_cnt <= '0;
            blink       <= 1'b0;
        end else if (r_blink_cnt >= c_BLINK_LAST) begin
            r_blink_cnt <= '0;
            blink       <= ~blink;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs, driven from next-state so they reflect a mode
    // change in the cycle right after the detected edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            set_mode   <= 1'b0;
            set_enable <= 1'b0;
            field_sel  <= 6'b000000;
            inc        <= 1'b0;
            dec        <= 1'b0;
        end else begin
            set_mode   <= (w_state_nxt != ST_RUN);
            set_enable <= (w_state_nxt != ST_RUN);
            field_sel  <= w_field_nxt;
            inc        <= w_inc_fire;
            dec        <= w_dec_fire;
        end
    end

endmodule
`default_nettype wire

// File: doc/clock_set_controller.md
CLOCK_SET_CONTROLLER -- requirements
Module: clock_set_controller

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1000, sets the idle cycles in any SET state before automatic return to RUN.
REQ-002 Parameter REPEAT_DELAY, default 500, sets the cycles a held inc/dec must stay asserted before the first auto-repeat pulse.
REQ-003 Parameter REPEAT_RATE, default 100, sets the cycles between successive auto-repeat pulses.
REQ-004 Parameter BLINK_HALF, default 250, sets the cycles per half-period of the blink output.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rstn  input  1  asynchronous, active-low reset.
REQ-007 btn_mode  input  1  debounced, synchronous, level-high mode button.
REQ-008 btn_inc  input  1  debounced, synchronous, level-high increment button.
REQ-009 btn_dec  input  1  debounced, synchronous, level-high decrement button.
REQ-010 set_mode  output  1  high in every SET state; low in RUN.
REQ-011 set_enable  output  1  high in every SET state; low in RUN.
REQ-012 field_sel  output  6  one-hot field being set: bit0 sec, bit1 min, bit2 hour, bit3 day, bit4 month, bit5 year; all-zero in RUN.
REQ-013 inc  output  1  single-cycle increment pulse to the selected field counter.
REQ-014 dec  output  1  single-cycle decrement pulse to the selected field counter.
REQ-015 blink  output  1  display blink enable for the selected field; low in RUN.

Function
REQ-016 The FSM SHALL have the states RUN, SET_SEC, SET_MIN, SET_HOUR, SET_DAY, SET_MON and SET_YEAR.
REQ-017 Each rising edge of btn_mode (low in the previous cycle, high now) SHALL advance the state RUN->SET_SEC->SET_MIN->SET_HOUR->SET_DAY->SET_MON->SET_YEAR->RUN.
REQ-018 Registered outputs SHALL reflect the new state one cycle after the detected edge.
REQ-019 In a SET state, a rising edge of btn_inc SHALL produce exactly one inc pulse in the following cycle; btn_dec SHALL likewise produce one dec pulse.
REQ-020 inc and dec SHALL never be high in the same cycle.
REQ-021 If btn_inc and btn_dec are both high, no pulse SHALL be produced, and an active repeat sequence SHALL be cancelled.
REQ-022 A btn_mode edge SHALL take priority: inc/dec edges detected in the same cycle SHALL be discarded.
REQ-023 A btn_mode edge SHALL cancel any active repeat sequence.
REQ-024 In RUN, btn_inc and btn_dec SHALL be ignored; inc and dec SHALL stay 0.
REQ-025 A 1-bit repeat FSM (IDLE, HOLD) SHALL start a hold counter on the initial pulse.
REQ-026 After REPEAT_DELAY cycles of continued hold, one pulse SHALL be emitted, followed by one pulse every REPEAT_RATE cycles until release.
REQ-027 Release SHALL return the repeat FSM to IDLE and clear the hold counter.
REQ-028 An idle counter SHALL run in SET states and clear on any button edge or state change.
REQ-029 When the idle counter reaches TIMEOUT_CYC-1, the state SHALL return to RUN on the next cycle.
REQ-030 In RUN the idle counter SHALL hold at 0.
REQ-031 The blink counter SHALL toggle blink every BLINK_HALF cycles in SET states.
REQ-032 On each state change, blink SHALL restart high with the blink counter at 0.
REQ-033 Every counter width SHALL be $clog2(parameter+1); counters SHALL saturate rather than wrap.

Reset
REQ-034 While rstn is low: state = RUN; all counters = 0; set_mode, set_enable, inc, dec, blink = 0; field_sel = 6'b000000; button history registers = 0.
REQ-035 If rstn asserts mid-operation, including during a repeat sequence, the block SHALL abort immediately, and no pulse SHALL be emitted after deassertion until a new button edge.

Configuration
REQ-036 With macro CLOCK_SET_AUTO_REPEAT_EN defined, the repeat logic of REQ-025 to REQ-027 SHALL be compiled in.
REQ-037 Without CLOCK_SET_AUTO_REPEAT_EN, the repeat logic SHALL be absent, and each button press SHALL produce exactly one pulse regardless of hold length.

Verification (TIMEOUT_CYC=20, REPEAT_DELAY=8, REPEAT_RATE=3, BLINK_HALF=4)
REQ-038 7 btn_mode presses from reset -> field_sel 000001, 000010, 000100, 001000, 010000, 100000, then 000000 with set_mode=0 after the seventh press.
REQ-039 SET_MIN, btn_inc held 20 cycles, macro defined -> inc pulses at cycle 1, 9, 12, 15, 18 after the edge; macro undefined -> one pulse at cycle 1 only.
REQ-040 SET_SEC, btn_inc and btn_dec rise together -> no inc or dec pulse; then btn_dec alone rises -> one dec pulse.
REQ-041 SET_HOUR with no button activity -> state returns to RUN 20 cycles after the last edge; set_mode and field_sel clear one cycle later.
REQ-042 In RUN, pulse btn_inc -> no inc pulse; in SET_DAY, rstn low during a hold -> all outputs 0 and no pulse after release of rstn.
